uart_tx: RTL

- UART transmit engine driven by the baud-tick pulse from the clock divider (`o_clk_tx`: a one-`clk`-wide pulse every 651 clocks).
- Accepts one parallel word per handshake and serialises it LSB-first on `o_tx` as start, data, optional parity and stop bits.
- Bit boundaries align to tick pulses only; no internal baud counter.
- Sits between the host/register interface and the TX pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM state encoding,
// default frame shape and the baud divider terminal count.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 1;

  // Terminal count of the existing baud divider (one tick every 651 clk).
  localparam int DIV_TC = 650;

endpackage

// File: rtl/uart_tx.sv
// UART transmit engine: serialises one captured word LSB-first as start, data,
// optional parity and stop bits, advancing one bit per external baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_tick,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done,
  output uart_state_e          o_dbg_state
);

  localparam int IDX_W = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 last_stop;

  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Handshake: i_start is a level request sampled every clk; it is accepted
  // only in IDLE (o_busy low), where i_data is captured in that same cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          shift_d = i_data;
          par_d   = (^i_data) ^ 1'(PARITY_ODD);
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (i_tick) state_d = START;
      end
      START: begin
        if (i_tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (i_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
            end else begin
              stop_d  = 1'b0;
              state_d = STOP;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (i_tick) begin
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (i_tick) begin
          if (last_stop) state_d = IDLE;
          else           stop_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value is derived from the next state so o_tx moves with the tick edge.
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state_q == STOP) && i_tick && last_stop;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx        = tx_q;
  assign o_done      = done_q;
  assign o_busy      = (state_q != IDLE);
  assign o_dbg_state = state_q;

endmodule
